display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
//  Downstream display stage for the uP core. Consumes four 4-bit nibbles
//  (e.g. accu, FF_out, data_bus, oprnd) and time-multiplexes them onto a
//  4-digit common-anode 7-segment display as hex. Has a prescaled scan FSM,
//  a blanking gap between digits (anti-ghosting), and per-digit snapshots.
// PARAMETERS
//  REFRESH_DIV   50000  clocks each digit is lit (>=1)
//  BLANK_CYCLES  500    clocks with all anodes off between digits (0 = no gap)
// PORTS
//  clock    in   1   single system clock, rising edge
//  reset    in   1   asynchronous, active-high
//  enable   in   1   1 = scan runs; 0 = display dark, scan parked
//  digit0   in   4   nibble for digit 0 (rightmost)
//  digit1   in   4   nibble for digit 1
//  digit2   in   4   nibble for digit 2
//  digit3   in   4   nibble for digit 3 (leftmost)
//  blank    in   4   blank[i]=1: digit i never lit; its slot timing is kept
//  dp       in   4   dp[i]=1: decimal point lit with digit i
//  seg_n    out  7   segments {g,f,e,d,c,b,a}, active-low, registered
//  dp_n     out  1   decimal point, active-low, registered
//  an_n     out  4   anodes, active-low, one-hot-low or all 1, registered
// BEHAVIOUR
//  - Reset (async) forces an_n=4'b1111, seg_n=7'b1111111, dp_n=1,
//    state=BLANK, idx=0, cnt=0. The reset is applied immediately, also mid-scan.
//  - FSM has 2 states. BLANK: an_n=1111 for BLANK_CYCLES clocks. SHOW: one
//    anode low for REFRESH_DIV clocks.
//  - BLANK->SHOW on the edge where cnt==BLANK_CYCLES-1, or immediately if
//    BLANK_CYCLES==0. On that edge:
//    - snapshot digit[idx] and dp[idx] into seg_n/dp_n;
//    - an_n[idx]<=0 unless blank[idx];
//    - cnt<=0.
//  - SHOW->BLANK on the edge where cnt==REFRESH_DIV-1. On that edge:
//    - an_n<=1111, seg_n<=1111111, dp_n<=1;
//    - idx<=idx+1 mod 4 (3 wraps to 0);
//    - cnt<=0.
//    With BLANK_CYCLES==0, SHOW goes directly to the next SHOW, with the snapshot
//    taken for the new idx.
//  - Snapshot rule: changes to digitN/dp/blank during a SHOW window do not
//    change outputs until that digit's next slot. Worst-case latency is
//    4*(REFRESH_DIV+BLANK_CYCLES) clocks.
//  - enable=0: the next edge forces BLANK outputs (all off), state=BLANK, cnt=0,
//    and idx is held. When enable returns to 1, a full BLANK gap runs, then
//    digit idx is shown.
//  - Counter width is CNT_W = clog2(max(REFRESH_DIV,BLANK_CYCLES,2)). cnt never
//    exceeds the limit of the active state.
//  - Hex map, active-low {g..a}:
//    0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//    C=1000110 d=0100001 E=0000110 F=0001110
//  - At most one an_n bit is low at any time. an_n changes only on BLANK
//    boundaries and never goes directly from one digit to another unless
//    BLANK_CYCLES==0.
// STRUCTURE
//  - Shared header seg_defs.vh holds:
//    - the 16 segment-pattern constants (SEG_0..SEG_F);
//    - the SEG_OFF and AN_OFF constants;
//    - the state encodings ST_BLANK and ST_SHOW.
//  - One sub-module, hex_to_seg, is purely combinational: 4-bit nibble in,
//    active-low 7-bit pattern out. It is reusable by other display paths.
//  - The top holds the FSM, cnt, idx, the 4:1 input mux and the output registers.
// TESTING  (REFRESH_DIV=4, BLANK_CYCLES=2 unless stated)
//  1. Hold reset, then release. Outputs are all off during reset; an_n=1110
//     after 2 edges, held 4 edges, then 1111 for 2 edges.
//  2. digits 3..0 = F,A,2,1, dp=0. Slots show:
//     an_n 1110/seg 1111001, 1101/0100100, 1011/0001000, 0111/0001110,
//     then 1110 again (wrap).
//  3. blank=0100. During digit2's 4-clock window an_n stays 1111. Slot timing
//     of digits 0, 1 and 3 is unchanged.
//  4. Change digit0 1->8 during its SHOW window. seg_n stays 1111001 until the
//     window ends; the next digit0 slot shows 0000000.
//  5. Drop enable mid-SHOW of digit1. All outputs are off at the next edge.
//     Raise enable: 2 blank clocks, then an_n=1101.
//  6. Assert reset mid-SHOW, asynchronously between edges. Outputs are off
//     immediately; after release the scan restarts at digit0. Also run with
//     BLANK_CYCLES=0: an_n steps 1110->1101 with no gap.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared definitions for the 7-segment display path: scan FSM states,
// active-low segment patterns {g,f,e,d,c,b,a} for hex 0..F, and the
// all-off values for segments and anodes.
package display_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/display_scan_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble  in  4  value 0..F
//   seg_n   out 7  active-low segment pattern {g,f,e,d,c,b,a}
module hex_to_seg
  import display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    unique case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexes four hex nibbles onto a 4-digit
// common-anode 7-segment display, with an all-dark gap between digits
// and a per-digit snapshot taken when each digit's slot starts.
// Ports:
//   clock          in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-high
//   enable         in   1  1 = scan runs, 0 = dark and parked
//   digit0..digit3 in   4  nibbles, digit0 rightmost
//   blank          in   4  blank[i]=1 keeps digit i dark (slot timing kept)
//   dp             in   4  dp[i]=1 lights the decimal point with digit i
//   seg_n          out  7  segments {g..a}, active-low, registered
//   dp_n           out  1  decimal point, active-low, registered
//   an_n           out  4  anodes, active-low, registered
module display_scan
  import display_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blank,
  input  logic [3:0] dp,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n
);

  localparam int unsigned CNT_MAX =
    (REFRESH_DIV > BLANK_CYCLES) ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                                 : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx, sel;
  logic [3:0]       nib;
  logic [6:0]       seg_lut, seg_nx;
  logic             dp_nx;
  logic [3:0]       an_nx;
  logic [3:0]       snap_an;
  logic             snap_dp;

  // The snapshot is always for the digit about to be shown: idx when
  // leaving BLANK, idx+1 when chaining SHOW->SHOW with no gap.
  always_comb begin
    sel = (state == ST_SHOW) ? idx + 2'd1 : idx;
    nib = digit0;
    unique case (sel)
      2'd0: nib = digit0;
      2'd1: nib = digit1;
      2'd2: nib = digit2;
      2'd3: nib = digit3;
    endcase
    snap_dp = ~dp[sel];
    snap_an = blank[sel] ? AN_OFF : ~(4'b0001 << sel);
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nib),
    .seg_n  (seg_lut)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    seg_nx   = seg_n;
    dp_nx    = dp_n;
    an_nx    = an_n;
    if (!enable) begin
      state_nx = ST_BLANK;
      cnt_nx   = '0;
      seg_nx   = SEG_OFF;
      dp_nx    = 1'b1;
      an_nx    = AN_OFF;
    end else begin
      unique case (state)
        ST_BLANK: begin
          if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
            state_nx = ST_SHOW;
            cnt_nx   = '0;
            seg_nx   = seg_lut;
            dp_nx    = snap_dp;
            an_nx    = snap_an;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx = '0;
            idx_nx = idx + 2'd1;
            if (BLANK_CYCLES == 0) begin
              seg_nx = seg_lut;
              dp_nx  = snap_dp;
              an_nx  = snap_an;
            end else begin
              state_nx = ST_BLANK;
              seg_nx   = SEG_OFF;
              dp_nx    = 1'b1;
              an_nx    = AN_OFF;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      an_n  <= AN_OFF;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
      an_n  <= an_nx;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] digit0 = 4'h0, digit1 = 4'h0, digit2 = 4'h0, digit3 = 4'h0;
  logic [3:0] blank = 4'b0000;
  logic [3:0] dp = 4'b0000;
  logic [6:0] seg_n, seg_n_z;
  logic       dp_n, dp_n_z;
  logic [3:0] an_n, an_n_z;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  display_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .dp(dp), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  display_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_nogap (
    .clock(clock), .reset(reset), .enable(enable),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .dp(dp), .seg_n(seg_n_z), .dp_n(dp_n_z), .an_n(an_n_z)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit after edge 0; the next edge is edge 1.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    digit0 = 4'h0; digit1 = 4'h0; digit2 = 4'h0; digit3 = 4'h0;
    blank = 4'b0000; dp = 4'b0000; enable = 1'b1;
    reset = 1'b1;
    tick(3);
    vectors++;
    if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || dp_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: an_n=%b seg_n=%b dp_n=%b, want 1111/1111111/1", an_n, seg_n, dp_n);
    end
    vectors++;
    if (an_n_z !== 4'b1111 || seg_n_z !== 7'b1111111 || dp_n_z !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold_nogap: an_n=%b seg_n=%b dp_n=%b, want 1111/1111111/1", an_n_z, seg_n_z, dp_n_z);
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (an_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_edge1: an_n=%b want 1111", an_n);
    end
    tick(1);
    vectors++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_first_slot: an_n=%b seg_n=%b want 1110/1000000", an_n, seg_n);
    end
    tick(3);
    vectors++;
    if (an_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_slot_hold: an_n=%b want 1110", an_n);
    end
    tick(1);
    vectors++;
    if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
      miscompares++;
      $display("FAIL reset_gap1: an_n=%b seg_n=%b want 1111/1111111", an_n, seg_n);
    end
    tick(1);
    vectors++;
    if (an_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_gap2: an_n=%b want 1111", an_n);
    end
    tick(1);
    vectors++;
    if (an_n !== 4'b1101) begin
      miscompares++;
      $display("FAIL reset_second_slot: an_n=%b want 1101", an_n);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_exp [5] = '{7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110, 7'b1111001};
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    blank = 4'b0000; dp = 4'b0000;
    do_reset();
    tick(2);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (an_n !== an_exp[k] || seg_n !== seg_exp[k] || dp_n !== 1'b1) begin
        miscompares++;
        $display("FAIL scan_slot%0d: an_n=%b seg_n=%b dp_n=%b want %b/%b/1",
                 k, an_n, seg_n, dp_n, an_exp[k], seg_exp[k]);
      end
      if (k < 4) begin
        tick(4);
        vectors++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
          miscompares++;
          $display("FAIL scan_gap%0d: an_n=%b seg_n=%b want 1111/1111111", k, an_n, seg_n);
        end
        tick(2);
      end
    end
  endtask

  task automatic test_dp();
    digit0 = 4'h3; digit1 = 4'hC;
    dp = 4'b0001; blank = 4'b0000;
    do_reset();
    tick(2);
    vectors++;
    if (dp_n !== 1'b0 || seg_n !== 7'b0110000) begin
      miscompares++;
      $display("FAIL dp_digit0: dp_n=%b seg_n=%b want 0/0110000", dp_n, seg_n);
    end
    tick(6);
    vectors++;
    if (dp_n !== 1'b1 || seg_n !== 7'b1000110 || an_n !== 4'b1101) begin
      miscompares++;
      $display("FAIL dp_digit1: dp_n=%b seg_n=%b an_n=%b want 1/1000110/1101", dp_n, seg_n, an_n);
    end
    dp = 4'b0000;
  endtask

  task automatic test_blank();
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    blank = 4'b0100;
    do_reset();
    tick(2);
    vectors++;
    if (an_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL blank_slot0: an_n=%b want 1110", an_n);
    end
    tick(6);
    vectors++;
    if (an_n !== 4'b1101) begin
      miscompares++;
      $display("FAIL blank_slot1: an_n=%b want 1101", an_n);
    end
    tick(5);
    for (int e = 0; e < 5; e++) begin
      tick(1);
      vectors++;
      if (an_n !== 4'b1111) begin
        miscompares++;
        $display("FAIL blank_slot2_edge%0d: an_n=%b want 1111", e, an_n);
      end
    end
    tick(2);
    vectors++;
    if (an_n !== 4'b0111 || seg_n !== 7'b0001110) begin
      miscompares++;
      $display("FAIL blank_slot3: an_n=%b seg_n=%b want 0111/0001110", an_n, seg_n);
    end
    blank = 4'b0000;
  endtask

  task automatic test_snapshot();
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    do_reset();
    tick(2);
    digit0 = 4'h8;
    tick(3);
    vectors++;
    if (seg_n !== 7'b1111001 || an_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL snapshot_hold: seg_n=%b an_n=%b want 1111001/1110", seg_n, an_n);
    end
    tick(21);
    vectors++;
    if (seg_n !== 7'b0000000 || an_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL snapshot_next: seg_n=%b an_n=%b want 0000000/1110", seg_n, an_n);
    end
  endtask

  task automatic test_enable();
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    enable = 1'b1;
    do_reset();
    tick(9);
    vectors++;
    if (an_n !== 4'b1101) begin
      miscompares++;
      $display("FAIL enable_pre: an_n=%b want 1101", an_n);
    end
    enable = 1'b0;
    tick(1);
    vectors++;
    if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || dp_n !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_off: an_n=%b seg_n=%b dp_n=%b want 1111/1111111/1", an_n, seg_n, dp_n);
    end
    tick(2);
    enable = 1'b1;
    tick(1);
    vectors++;
    if (an_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL enable_gap: an_n=%b want 1111", an_n);
    end
    tick(1);
    vectors++;
    if (an_n !== 4'b1101 || seg_n !== 7'b0100100) begin
      miscompares++;
      $display("FAIL enable_resume: an_n=%b seg_n=%b want 1101/0100100", an_n, seg_n);
    end
  endtask

  task automatic test_async_reset();
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    do_reset();
    tick(9);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || dp_n !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: an_n=%b seg_n=%b dp_n=%b want 1111/1111111/1", an_n, seg_n, dp_n);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(2);
    vectors++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1111001) begin
      miscompares++;
      $display("FAIL async_restart: an_n=%b seg_n=%b want 1110/1111001", an_n, seg_n);
    end
  endtask

  task automatic test_no_gap();
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'hA; digit3 = 4'hF;
    do_reset();
    tick(1);
    vectors++;
    if (an_n_z !== 4'b1110 || seg_n_z !== 7'b1111001) begin
      miscompares++;
      $display("FAIL nogap_slot0: an_n=%b seg_n=%b want 1110/1111001", an_n_z, seg_n_z);
    end
    tick(3);
    vectors++;
    if (an_n_z !== 4'b1110) begin
      miscompares++;
      $display("FAIL nogap_hold: an_n=%b want 1110", an_n_z);
    end
    tick(1);
    vectors++;
    if (an_n_z !== 4'b1101 || seg_n_z !== 7'b0100100) begin
      miscompares++;
      $display("FAIL nogap_step: an_n=%b seg_n=%b want 1101/0100100", an_n_z, seg_n_z);
    end
    tick(12);
    vectors++;
    if (an_n_z !== 4'b1110 || seg_n_z !== 7'b1111001) begin
      miscompares++;
      $display("FAIL nogap_wrap: an_n=%b seg_n=%b want 1110/1111001", an_n_z, seg_n_z);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_dp();
    test_blank();
    test_snapshot();
    test_enable();
    test_async_reset();
    test_no_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
